uart_word_tx: RTL and testbench

- Serial output stage downstream of the MIPS core.
- Accepts a 32-bit word on the core's SerialOutEn/SerialData strobe and transmits it as 4 UART bytes (8N1).
- Returns the TX_flag completion pulse that the core waits on before issuing the next word.

---
 rtl/uart_pkg.sv | 16 +
 rtl/baud_tick_gen.sv | 25 ++
 rtl/uart_word_tx.sv | 125 ++++++++++++
 tb/tb_uart_word_tx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and line-level constants for the word UART
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } uart_state_t;

    localparam int   DEFAULT_BAUD_DIV = 434;
    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic START_BIT        = 1'b0;

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - bit-period counter, tick on the last cycle of each bit
module baud_tick_gen #(
    parameter int BAUD_DIV = uart_pkg::DEFAULT_BAUD_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(BAUD_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_word_tx.sv
// rtl/uart_word_tx.sv - sends a latched word as consecutive 8N1 bytes, LSB byte first
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int WORD_LENGTH = 32,
    parameter int NBITS       = 8,
    parameter int BAUD_DIV    = DEFAULT_BAUD_DIV
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   SerialOutEn,
    input  logic [WORD_LENGTH-1:0] SerialData,
    output logic                   tx,
    output logic                   busy,
    output logic                   TX_flag
);

    localparam int NBYTES = WORD_LENGTH / NBITS;
    localparam int BIT_W  = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    uart_state_t            state, state_d;
    logic [WORD_LENGTH-1:0] shreg, shreg_d;
    logic [BIT_W-1:0]       bit_cnt, bit_cnt_d;
    logic [BYTE_W-1:0]      byte_cnt, byte_cnt_d;
    logic                   tx_d, busy_d, flag_d;
    logic                   accept, bit_tick, baud_clear;

    // Restarting the counter on every state change keeps every bit full length.
    assign baud_clear = accept || (state_d != state);

    baud_tick_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (baud_clear),
        .tick  (bit_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            tx       <= UART_IDLE_LEVEL;
            busy     <= 1'b0;
            TX_flag  <= 1'b0;
        end else begin
            state    <= state_d;
            shreg    <= shreg_d;
            bit_cnt  <= bit_cnt_d;
            byte_cnt <= byte_cnt_d;
            tx       <= tx_d;
            busy     <= busy_d;
            TX_flag  <= flag_d;
        end
    end

    always_comb begin
        state_d    = state;
        shreg_d    = shreg;
        bit_cnt_d  = bit_cnt;
        byte_cnt_d = byte_cnt;
        tx_d       = tx;
        busy_d     = busy;
        flag_d     = 1'b0;
        accept     = 1'b0;

        case (state)
            IDLE: begin
                accept = SerialOutEn;
            end
            START: begin
                if (bit_tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    tx_d      = shreg[0];
                end
            end
            DATA: begin
                // Shifting after the last bit too leaves the next byte at the bottom.
                if (bit_tick) begin
                    shreg_d = shreg >> 1;
                    if (bit_cnt == BIT_W'(NBITS - 1)) begin
                        state_d = STOP;
                        tx_d    = UART_IDLE_LEVEL;
                    end else begin
                        bit_cnt_d = bit_cnt + BIT_W'(1);
                        tx_d      = shreg[1];
                    end
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (byte_cnt == BYTE_W'(NBYTES - 1)) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        flag_d  = 1'b1;
                    end else begin
                        byte_cnt_d = byte_cnt + BYTE_W'(1);
                        state_d    = START;
                        tx_d       = START_BIT;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                accept  = SerialOutEn;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            shreg_d    = SerialData;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            state_d    = START;
            tx_d       = START_BIT;
            busy_d     = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// tb/tb_uart_word_tx.sv - self-checking bench for uart_word_tx at BAUD_DIV 4, 2 and 434
module tb_uart_word_tx;

    typedef struct {
        logic [31:0]     word;
        int              inj;
        bit              chain;
        logic [3:0][7:0] exp_b;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_drv;
    logic [1:0]  sel;
    logic [31:0] data;
    logic        tx4, busy4, flag4;
    logic        tx2, busy2, flag2;
    logic        tx434, busy434, flag434;
    logic        obs_tx, obs_busy, obs_flag;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_word_tx #(.WORD_LENGTH(32), .NBITS(8), .BAUD_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .SerialOutEn(en_drv && sel == 2'd0), .SerialData(data),
        .tx(tx4), .busy(busy4), .TX_flag(flag4)
    );
    uart_word_tx #(.WORD_LENGTH(32), .NBITS(8), .BAUD_DIV(2)) dut2 (
        .clk(clk), .reset(reset), .SerialOutEn(en_drv && sel == 2'd1), .SerialData(data),
        .tx(tx2), .busy(busy2), .TX_flag(flag2)
    );
    uart_word_tx #(.WORD_LENGTH(32), .NBITS(8), .BAUD_DIV(434)) dut434 (
        .clk(clk), .reset(reset), .SerialOutEn(en_drv && sel == 2'd2), .SerialData(data),
        .tx(tx434), .busy(busy434), .TX_flag(flag434)
    );

    always_comb begin
        case (sel)
            2'd1:    begin obs_tx = tx2;   obs_busy = busy2;   obs_flag = flag2;   end
            2'd2:    begin obs_tx = tx434; obs_busy = busy434; obs_flag = flag434; end
            default: begin obs_tx = tx4;   obs_busy = busy4;   obs_flag = flag4;   end
        endcase
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Line level k cycles after the strobe cycle: 40 bit slots of bd cycles each.
    function automatic logic exp_tx(input logic [31:0] w, input int bd, input int k);
        int slot, byte_i, pos;
        if (k < 1 || k > 40 * bd) return 1'b1;
        slot   = (k - 1) / bd;
        byte_i = slot / 10;
        pos    = slot % 10;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return w[byte_i * 8 + pos - 1];
    endfunction

    task automatic run_word(input logic [31:0] w, input int bd, input bit pre, input int inj,
                            input bit chain, input logic [31:0] cw,
                            input logic [3:0][7:0] exp_b, input string tag);
        int   last = 40 * bd + 1;
        int   tx_bad = 0, busy_bad = 0, flag_bad = 0, flag_cnt = 0, first_bad = 0;
        logic trace[$];
        logic [7:0] got_b;
        int   frame_bad = 0;
        if (!pre) begin
            en_drv = 1'b1;
            data   = w;
        end
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            trace.push_back(obs_tx);
            if (obs_tx !== exp_tx(w, bd, k)) begin
                if (tx_bad == 0) first_bad = k;
                tx_bad++;
            end
            if (obs_busy !== (k < last)) busy_bad++;
            if (obs_flag !== (k == last)) flag_bad++;
            if (obs_flag === 1'b1) flag_cnt++;
            en_drv = 1'b0;
            data   = $urandom;
            if (k == inj) begin
                en_drv = 1'b1;
                data   = 32'hFFFF_FFFF;
            end
            if (k == last && chain) begin
                en_drv = 1'b1;
                data   = cw;
            end
        end
        check({tag, " tx waveform bad cycles (first at cycle ", $sformatf("%0d", first_bad), ")"},
              tx_bad, 0);
        check({tag, " busy bad cycles"}, busy_bad, 0);
        check({tag, " TX_flag timing bad cycles"}, flag_bad, 0);
        check({tag, " TX_flag pulse count"}, flag_cnt, 1);
        for (int b = 0; b < 4; b++) begin
            if (trace[(b * 10) * bd + bd / 2] !== 1'b0) frame_bad++;
            if (trace[(b * 10 + 9) * bd + bd / 2] !== 1'b1) frame_bad++;
            for (int i = 0; i < 8; i++) got_b[i] = trace[(b * 10 + 1 + i) * bd + bd / 2];
            check({tag, $sformatf(" decoded byte %0d", b)}, got_b, exp_b[b]);
        end
        check({tag, " start/stop framing errors"}, frame_bad, 0);
        if (!chain) begin
            @(negedge clk);
            check({tag, " idle after word tx/busy/flag"}, {obs_tx, obs_busy, obs_flag}, 3'b100);
        end
    endtask

    initial begin
        vec_t        tbl[$];
        vec_t        v;
        bit          pre;
        logic [31:0] nxt, rw;
        int          bad;

        reset  = 1'b1;
        en_drv = 1'b0;
        sel    = 2'd0;
        data   = '0;
        repeat (3) @(negedge clk);
        check("reset state tx/busy/flag", {tx4, busy4, flag4, tx2, busy2, tx434, busy434}, 7'b1001010);
        reset = 1'b0;

        bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            data = $urandom;
            if ({tx4, busy4, flag4, tx2, busy2, flag2, tx434, busy434, flag434} !== 9'b100100100) bad++;
        end
        check("idle 50 cycles bad samples", bad, 0);

        tbl.push_back('{32'hA5C3_0F81, 0,  1'b0, {8'hA5, 8'hC3, 8'h0F, 8'h81}});
        tbl.push_back('{32'hA5C3_0F81, 80, 1'b1, {8'hA5, 8'hC3, 8'h0F, 8'h81}});
        tbl.push_back('{32'h0000_0000, 0,  1'b0, {8'h00, 8'h00, 8'h00, 8'h00}});
        for (int i = 0; i < 6; i++) begin
            rw = $urandom;
            tbl.push_back('{rw, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 159)) : 0,
                            (i < 5) ? bit'($urandom_range(0, 1)) : 1'b0,
                            {rw[31:24], rw[23:16], rw[15:8], rw[7:0]}});
        end

        pre = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            v   = tbl[i];
            nxt = (i + 1 < tbl.size()) ? tbl[i + 1].word : 32'h0;
            run_word(v.word, 4, pre, v.inj, v.chain, nxt, v.exp_b, $sformatf("vec%0d", i));
            pre = v.chain;
        end

        // Reset in byte 2, bit 3: abandons the frame without a completion pulse.
        en_drv = 1'b1;
        data   = 32'hDEAD_BEEF;
        for (int k = 1; k <= 98; k++) begin
            @(negedge clk);
            en_drv = 1'b0;
            data   = $urandom;
            if (k == 98) reset = 1'b1;
        end
        @(negedge clk);
        check("mid-frame reset tx", tx4, 1);
        check("mid-frame reset busy", busy4, 0);
        check("mid-frame reset TX_flag", flag4, 0);
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if ({tx4, busy4, flag4} !== 3'b100) bad++;
        end
        check("post-reset quiet bad samples", bad, 0);
        run_word(32'h1234_5678, 4, 1'b0, 0, 1'b0, 32'h0, {8'h12, 8'h34, 8'h56, 8'h78}, "after_reset");

        sel = 2'd1;
        run_word(32'h8000_0001, 2, 1'b0, 0, 1'b0, 32'h0, {8'h80, 8'h00, 8'h00, 8'h01}, "baud2");
        sel = 2'd2;
        run_word(32'h8000_0001, 434, 1'b0, 0, 1'b0, 32'h0, {8'h80, 8'h00, 8'h00, 8'h01}, "baud434");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
